// File: rtl/axi4_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between one master and the memory/MMIO slave.
// Address channels are fixed at 32 bits; data width follows DATA_WIDTH.
interface axi4_lite_mem_slave_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  awvalid;
  logic                  awready;
  logic [31:0]           awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [31:0]           araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb,    output wready,
    output bvalid, bresp,           input  bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp,    input  rready
  );

  modport master (
    output awvalid, awaddr, awprot, input  awready,
    output wvalid, wdata, wstrb,    input  wready,
    input  bvalid, bresp,           output bready,
    output arvalid, araddr, arprot, input  arready,
    input  rvalid, rdata, rresp,    output rready
  );
endinterface

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite RAM slave with test-harness MMIO (pass flag, report word, UART TX).
// Independent read and write FSMs, each with a configurable response latency.
module axi4_lite_mem_slave #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          MEM_BYTES      = 65536,
  parameter int          RD_LATENCY     = 0,
  parameter int          WR_LATENCY     = 0,
  parameter logic [31:0] PASS_ADDR      = 32'h0000_1000,
  parameter logic [31:0] PASS_VALUE     = 32'd123456789,
  parameter logic [31:0] REPORT_ADDR    = 32'h0000_1004,
  parameter logic [31:0] UART_TX_ADDR   = 32'hE000_1030,
  parameter logic [31:0] UART_STAT_ADDR = 32'hE000_102C
) (
  input  logic                        clk,
  input  logic                        reset,
  axi4_lite_mem_slave_if.slave        bus,
  output logic                        tests_passed,
  output logic                        uart_valid,
  output logic [7:0]                  uart_data,
  output logic                        report_valid,
  output logic [31:0]                 report_data
);
  localparam int          BYTES       = DATA_WIDTH / 8;
  localparam int          ADDR_LSB    = $clog2(BYTES);
  localparam int          MEM_WORDS   = MEM_BYTES / BYTES;
  localparam int          IDX_W       = $clog2(MEM_WORDS);
  localparam logic [31:0] ADDR_MASK   = ~32'(BYTES - 1);
  localparam logic [31:0] MEM_LIMIT   = 32'(MEM_BYTES);
  localparam logic [3:0]  RD_LAST     = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_LAST     = 4'(WR_LATENCY - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [2:0] {DEC_RAM, DEC_PASS, DEC_REPORT, DEC_UART_TX, DEC_MMIO_RO, DEC_ERR} dec_e;

  // MMIO words take priority over RAM, so harness addresses inside the RAM window never touch RAM.
  function automatic dec_e decode(input logic [31:0] addr);
    logic [31:0] a;
    dec_e        d;
    a = addr & ADDR_MASK;
    if      (a == (PASS_ADDR & ADDR_MASK))      d = DEC_PASS;
    else if (a == (REPORT_ADDR & ADDR_MASK))    d = DEC_REPORT;
    else if (a == (UART_TX_ADDR & ADDR_MASK))   d = DEC_UART_TX;
    else if (a == (UART_STAT_ADDR & ADDR_MASK)) d = DEC_MMIO_RO;
    else if (a < MEM_LIMIT)                     d = DEC_RAM;
    else                                        d = DEC_ERR;
    return d;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  r_state_e              r_state_q, r_state_d;
  logic [3:0]            rd_cnt_q, rd_cnt_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_sample;
  dec_e                  rd_dec;

  w_state_e              w_state_q, w_state_d;
  logic [3:0]            wr_cnt_q, wr_cnt_d;
  logic                  aw_latched_q, aw_latched_d;
  logic                  w_latched_q, w_latched_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_commit;
  logic                  mem_we;
  dec_e                  wr_dec;

  logic                  tests_passed_q, tests_passed_d;
  logic                  uart_valid_q, uart_valid_d;
  logic [7:0]            uart_data_q, uart_data_d;
  logic                  report_valid_q, report_valid_d;
  logic [31:0]           report_data_q, report_data_d;

  logic                  unused_prot;
  assign unused_prot = ^{bus.awprot, bus.arprot};

  assign bus.arready   = (r_state_q == R_IDLE);
  assign bus.rvalid    = (r_state_q == R_RESP);
  assign bus.rdata     = rdata_q;
  assign bus.rresp     = rresp_q;
  assign bus.awready   = !aw_latched_q;
  assign bus.wready    = !w_latched_q;
  assign bus.bvalid    = (w_state_q == W_RESP);
  assign bus.bresp     = bresp_q;
  assign tests_passed  = tests_passed_q;
  assign uart_valid    = uart_valid_q;
  assign uart_data     = uart_data_q;
  assign report_valid  = report_valid_q;
  assign report_data   = report_data_q;

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    r_state_d = r_state_q;
    rd_cnt_d  = rd_cnt_q;
    araddr_d  = araddr_q;
    rd_sample = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          araddr_d = bus.araddr;
          rd_cnt_d = '0;
          if (RD_LATENCY == 0) begin
            r_state_d = R_RESP;
            rd_sample = 1'b1;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == RD_LAST) begin
          r_state_d = R_RESP;
          rd_sample = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end
      R_RESP:  if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read data is captured on the edge entering R_RESP, so a same-edge write is not yet visible.
  always_comb begin
    rd_dec  = decode(araddr_d);
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_sample) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      if (rd_dec == DEC_RAM)      rdata_d = mem[araddr_d[ADDR_LSB +: IDX_W]];
      else if (rd_dec == DEC_ERR) rresp_d = RESP_DECERR;
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    wr_cnt_d     = wr_cnt_q;
    aw_latched_d = aw_latched_q;
    w_latched_d  = w_latched_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wr_commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && !aw_latched_q) begin
          aw_latched_d = 1'b1;
          awaddr_d     = bus.awaddr;
        end
        if (bus.wvalid && !w_latched_q) begin
          w_latched_d = 1'b1;
          wdata_d     = bus.wdata;
          wstrb_d     = bus.wstrb;
        end
        if (aw_latched_d && w_latched_d) begin
          wr_cnt_d = '0;
          if (WR_LATENCY == 0) begin
            w_state_d = W_RESP;
            wr_commit = 1'b1;
          end else begin
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == WR_LAST) begin
          w_state_d = W_RESP;
          wr_commit = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d    = W_IDLE;
          aw_latched_d = 1'b0;
          w_latched_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_dec         = decode(awaddr_d);
    bresp_d        = bresp_q;
    tests_passed_d = tests_passed_q;
    uart_valid_d   = 1'b0;
    uart_data_d    = uart_data_q;
    report_valid_d = 1'b0;
    report_data_d  = report_data_q;
    mem_we         = 1'b0;
    if (wr_commit) begin
      bresp_d = (wr_dec == DEC_ERR) ? RESP_DECERR : RESP_OKAY;
      case (wr_dec)
        DEC_RAM:  mem_we = 1'b1;
        DEC_PASS: begin
          if (wdata_d[31:0] == PASS_VALUE && wstrb_d[3:0] == 4'hF) tests_passed_d = 1'b1;
        end
        DEC_REPORT: begin
          report_valid_d = 1'b1;
          report_data_d  = wdata_d[31:0];
        end
        DEC_UART_TX: begin
          uart_valid_d = 1'b1;
          uart_data_d  = wdata_d[7:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; its contents survive reset and come from external preload.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_d[b]) mem[awaddr_d[ADDR_LSB +: IDX_W]][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next-state logic lives in the always_comb blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q      <= R_IDLE;
      rd_cnt_q       <= '0;
      araddr_q       <= '0;
      rdata_q        <= '0;
      rresp_q        <= RESP_OKAY;
      w_state_q      <= W_IDLE;
      wr_cnt_q       <= '0;
      aw_latched_q   <= 1'b0;
      w_latched_q    <= 1'b0;
      awaddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      bresp_q        <= RESP_OKAY;
      tests_passed_q <= 1'b0;
      uart_valid_q   <= 1'b0;
      uart_data_q    <= '0;
      report_valid_q <= 1'b0;
      report_data_q  <= '0;
    end else begin
      r_state_q      <= r_state_d;
      rd_cnt_q       <= rd_cnt_d;
      araddr_q       <= araddr_d;
      rdata_q        <= rdata_d;
      rresp_q        <= rresp_d;
      w_state_q      <= w_state_d;
      wr_cnt_q       <= wr_cnt_d;
      aw_latched_q   <= aw_latched_d;
      w_latched_q    <= w_latched_d;
      awaddr_q       <= awaddr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      bresp_q        <= bresp_d;
      tests_passed_q <= tests_passed_d;
      uart_valid_q   <= uart_valid_d;
      uart_data_q    <= uart_data_d;
      report_valid_q <= report_valid_d;
      report_data_q  <= report_data_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed bench: a 32-bit instance with read/write latency and a 64-bit instance
// for strobe lanes above bit 31. Expected values are hand-computed constants.
module tb_axi4_lite_mem_slave;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_lite_mem_slave_if #(.DATA_WIDTH(32)) bus32 ();
  axi4_lite_mem_slave_if #(.DATA_WIDTH(64)) bus64 ();

  logic        tests_passed, uart_valid, report_valid;
  logic [7:0]  uart_data;
  logic [31:0] report_data;
  logic        tp64, uv64, rv64;
  logic [7:0]  ud64;
  logic [31:0] rpd64;

  axi4_lite_mem_slave #(
    .DATA_WIDTH(32), .MEM_BYTES(65536), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) u_dut32 (
    .clk(clk), .reset(reset), .bus(bus32),
    .tests_passed(tests_passed), .uart_valid(uart_valid), .uart_data(uart_data),
    .report_valid(report_valid), .report_data(report_data)
  );

  axi4_lite_mem_slave #(
    .DATA_WIDTH(64), .MEM_BYTES(4096), .RD_LATENCY(0), .WR_LATENCY(0)
  ) u_dut64 (
    .clk(clk), .reset(reset), .bus(bus64),
    .tests_passed(tp64), .uart_valid(uv64), .uart_data(ud64),
    .report_valid(rv64), .report_data(rpd64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          uart_cnt = 0;
  int          report_cnt = 0;
  logic [7:0]  uart_last = '0;
  logic [31:0] report_last = '0;
  always @(negedge clk) begin
    if (uart_valid)   begin uart_cnt++;   uart_last = uart_data;     end
    if (report_valid) begin report_cnt++; report_last = report_data; end
  end

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic wr32(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
    bit aw_pend, w_pend;
    int c;
    aw_pend = 1'b1; w_pend = 1'b1; c = 0;
    bus32.awaddr = addr; bus32.wdata = data; bus32.wstrb = strb; bus32.awprot = 3'b001;
    while ((aw_pend || w_pend) && c < 50) begin
      bus32.awvalid = aw_pend && (c >= aw_dly);
      bus32.wvalid  = w_pend && (c >= w_dly);
      @(negedge clk);
      if (bus32.awvalid && bus32.awready) aw_pend = 1'b0;
      if (bus32.wvalid && bus32.wready)   w_pend = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    bus32.awvalid = 1'b0; bus32.wvalid = 1'b0;
    check({tag, " accept"}, {aw_pend, w_pend}, 2'b00);
    bus32.bready = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus32.bvalid && c < 40);
    check({tag, " bvalid"}, bus32.bvalid, 1'b1);
    check({tag, " bresp"}, bus32.bresp, exp_resp);
    @(posedge clk); #1;
    bus32.bready = 1'b0;
    @(negedge clk);
    check({tag, " single b"}, bus32.bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic rd32(input string tag, input logic [31:0] addr, input int hold,
                      input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int c;
    bus32.araddr = addr; bus32.arprot = 3'b010; bus32.arvalid = 1'b1; bus32.rready = 1'b0;
    c = 0;
    @(negedge clk);
    while (!bus32.arready && c < 40) begin @(negedge clk); c++; end
    check({tag, " arready"}, bus32.arready, 1'b1);
    @(posedge clk); #1;
    bus32.arvalid = 1'b0;
    c = 0;
    @(negedge clk);
    while (!bus32.rvalid && c < 40) begin @(negedge clk); c++; end
    check({tag, " latency"}, c, RD_LAT);
    check({tag, " rdata"}, bus32.rdata, exp_data);
    check({tag, " rresp"}, bus32.rresp, exp_resp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold"}, {bus32.rvalid, bus32.rdata}, {1'b1, exp_data});
    end
    bus32.rready = 1'b1;
    @(posedge clk); #1;
    bus32.rready = 1'b0;
    @(negedge clk);
    check({tag, " rvalid drop"}, bus32.rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wr64(input string tag, input logic [31:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input logic [1:0] exp_resp);
    int c;
    bus64.awaddr = addr; bus64.wdata = data; bus64.wstrb = strb;
    bus64.awvalid = 1'b1; bus64.wvalid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!(bus64.awready && bus64.wready) && c < 40) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    bus64.awvalid = 1'b0; bus64.wvalid = 1'b0; bus64.bready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!bus64.bvalid && c < 40) begin @(negedge clk); c++; end
    check({tag, " bvalid"}, bus64.bvalid, 1'b1);
    check({tag, " bresp"}, bus64.bresp, exp_resp);
    @(posedge clk); #1;
    bus64.bready = 1'b0;
  endtask

  task automatic rd64(input string tag, input logic [31:0] addr, input logic [63:0] exp_data,
                      input logic [1:0] exp_resp);
    int c;
    bus64.araddr = addr; bus64.arvalid = 1'b1; bus64.rready = 1'b0;
    c = 0;
    @(negedge clk);
    while (!bus64.arready && c < 40) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    bus64.arvalid = 1'b0;
    c = 0;
    @(negedge clk);
    while (!bus64.rvalid && c < 40) begin @(negedge clk); c++; end
    check({tag, " rvalid"}, bus64.rvalid, 1'b1);
    check({tag, " rdata"}, bus64.rdata, exp_data);
    check({tag, " rresp"}, bus64.rresp, exp_resp);
    bus64.rready = 1'b1;
    @(posedge clk); #1;
    bus64.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int u0, r0;
  logic stray;

  initial begin
    bus32.awvalid = 0; bus32.awaddr = '0; bus32.awprot = '0; bus32.wvalid = 0; bus32.wdata = '0;
    bus32.wstrb = '0; bus32.bready = 0; bus32.arvalid = 0; bus32.araddr = '0; bus32.arprot = '0;
    bus32.rready = 0;
    bus64.awvalid = 0; bus64.awaddr = '0; bus64.awprot = '0; bus64.wvalid = 0; bus64.wdata = '0;
    bus64.wstrb = '0; bus64.bready = 0; bus64.arvalid = 0; bus64.araddr = '0; bus64.arprot = '0;
    bus64.rready = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst ready", {bus32.arready, bus32.awready, bus32.wready}, 3'b111);
    check("rst valid", {bus32.rvalid, bus32.bvalid}, 2'b00);
    check("rst resp", {bus32.rresp, bus32.bresp}, 4'b0000);
    check("rst rdata", bus32.rdata, 32'h0);
    check("rst flags", {tests_passed, uart_valid, report_valid}, 3'b000);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic write then read with latency and rready back-pressure
    wr32("w10", 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    rd32("r10", 32'h10, 4, 32'hDEADBEEF, 2'b00);
    rd32("r13 unaligned", 32'h13, 0, 32'hDEADBEEF, 2'b00);

    // W before AW by three cycles, partial strobe
    wr32("w20 full", 32'h20, 32'hAAAAAAAA, 4'hF, 0, 0, 2'b00);
    wr32("w20 part", 32'h20, 32'h11223344, 4'b0101, 3, 0, 2'b00);
    rd32("r20", 32'h20, 0, 32'hAA22AA44, 2'b00);

    // AW before W, top byte only; then wstrb=0 changes nothing
    wr32("w24 full", 32'h24, 32'h01020304, 4'hF, 0, 0, 2'b00);
    wr32("w24 top", 32'h24, 32'hFF000000, 4'b1000, 0, 2, 2'b00);
    rd32("r24", 32'h24, 0, 32'hFF020304, 2'b00);
    wr32("w24 nostrb", 32'h24, 32'hFFFFFFFF, 4'b0000, 0, 0, 2'b00);
    rd32("r24 nostrb", 32'h24, 0, 32'hFF020304, 2'b00);

    // Pass flag: only the exact value with all four low strobes
    wr32("pass wrong", 32'h1000, 32'd123456788, 4'hF, 0, 0, 2'b00);
    check("tp after wrong value", tests_passed, 1'b0);
    wr32("pass strb", 32'h1000, 32'd123456789, 4'b0111, 0, 0, 2'b00);
    check("tp after partial strb", tests_passed, 1'b0);
    wr32("pass ok", 32'h1000, 32'd123456789, 4'hF, 0, 0, 2'b00);
    check("tp set", tests_passed, 1'b1);
    wr32("pass clear try", 32'h1000, 32'h0, 4'hF, 0, 0, 2'b00);
    check("tp sticky", tests_passed, 1'b1);
    rd32("r pass addr", 32'h1000, 0, 32'h0, 2'b00);

    // UART and report pulses
    u0 = uart_cnt;
    wr32("uart", 32'hE000_1030, 32'h0000_0041, 4'b0001, 0, 0, 2'b00);
    check("uart pulses", uart_cnt - u0, 1);
    check("uart data", uart_last, 8'h41);
    r0 = report_cnt;
    wr32("report", 32'h1004, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00);
    check("report pulses", report_cnt - r0, 1);
    check("report data", report_last, 32'hCAFEF00D);
    rd32("r uart stat", 32'hE000_102C, 0, 32'h0, 2'b00);

    // Decode boundaries and unmapped accesses
    wr32("w0", 32'h0, 32'h13572468, 4'hF, 0, 0, 2'b00);
    rd32("r unmapped", 32'hF000_0000, 0, 32'h0, 2'b11);
    wr32("w unmapped", 32'hF000_0000, 32'hDEADBEEF, 4'hF, 0, 0, 2'b11);
    rd32("r0 unchanged", 32'h0, 0, 32'h13572468, 2'b00);
    wr32("w last word", 32'hFFFC, 32'h87654321, 4'hF, 0, 0, 2'b00);
    rd32("r last word", 32'hFFFC, 0, 32'h87654321, 2'b00);
    rd32("r mem end", 32'h1_0000, 0, 32'h0, 2'b11);

    // Read sample and write commit on the same edge: read sees the old word
    wr32("w40 old", 32'h40, 32'h11111111, 4'hF, 0, 0, 2'b00);
    fork
      rd32("r40 race", 32'h40, 0, 32'h11111111, 2'b00);
      begin
        @(posedge clk); #1;
        wr32("w40 new", 32'h40, 32'h22222222, 4'hF, 0, 0, 2'b00);
      end
    join
    rd32("r40 after", 32'h40, 0, 32'h22222222, 2'b00);

    // Reset with a read in R_WAIT and only AW latched
    bus32.araddr = 32'h10; bus32.arvalid = 1'b1;
    bus32.awaddr = 32'h50; bus32.awvalid = 1'b1;
    @(negedge clk);
    check("pre-rst accept", {bus32.arready, bus32.awready}, 2'b11);
    @(posedge clk); #1;
    bus32.arvalid = 1'b0; bus32.awvalid = 1'b0;
    @(negedge clk);
    check("in-flight ready", {bus32.arready, bus32.awready, bus32.wready}, 3'b001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-rst valid", {bus32.rvalid, bus32.bvalid}, 2'b00);
    check("post-rst ready", {bus32.arready, bus32.awready, bus32.wready}, 3'b111);
    check("post-rst tp", tests_passed, 1'b0);
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus32.rvalid || bus32.bvalid) stray = 1'b1;
    end
    check("no dropped response", stray, 1'b0);
    @(posedge clk); #1;
    wr32("w50 after rst", 32'h50, 32'h600DF00D, 4'hF, 0, 0, 2'b00);
    rd32("r50 after rst", 32'h50, 0, 32'h600DF00D, 2'b00);
    rd32("r10 kept", 32'h10, 0, 32'hDEADBEEF, 2'b00);

    // 64-bit lanes
    wr64("w64 init", 32'h8, 64'h11111111_22222222, 8'hFF, 2'b00);
    wr64("w64 upper", 32'h8, 64'h01234567_89ABCDEF, 8'hF0, 2'b00);
    rd64("r64", 32'h8, 64'h01234567_22222222, 2'b00);
    rd64("r64 unmapped", 32'h2000, 64'h0, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
